// File: rtl/reset_ctrl.sv
// rtl/reset_ctrl.sv - restart sequencer: button/watchdog/software requests to a fixed-length sys_rst
// Records the restart cause and a saturating restart count that survive sys_rst.
module reset_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int GUARD_CYCLES = 16,
  parameter int DB_CYCLES    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [15:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic        btn_in,
  input  logic        wd_trig,
  output logic        sys_rst
);

  localparam int TMAX = (RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, GUARD} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    cause;
  logic [7:0]    count;
  logic          sync_a, sync_b;
  logic [DW-1:0] db_cnt;
  logic          btn_evt;
  logic          wr, sw_req, clr, req;
  logic [7:0]    count_base;
  logic          busy;
  logic [7:0]    unused_bits;

  assign unused_bits = data_in[15:8];

  // Counter holds at DB_CYCLES so a held button yields exactly one event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
      if (!sync_b)
        db_cnt <= '0;
      else if (db_cnt != DW'(DB_CYCLES))
        db_cnt <= db_cnt + 1'b1;
    end
  end

  assign btn_evt    = sync_b && (db_cnt == DW'(DB_CYCLES - 1));
  assign wr         = stb & we;
  assign sw_req     = wr & data_in[0];
  assign clr        = wr & data_in[1];
  assign req        = btn_evt | wd_trig | sw_req;
  assign count_base = clr ? 8'd0 : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HOLD;
      timer   <= TW'(RST_CYCLES - 1);
      sys_rst <= 1'b1;
      cause   <= 4'b0001;
      count   <= 8'd0;
    end else begin
      count <= count_base;
      case (state)
        IDLE: begin
          if (req) begin
            state   <= HOLD;
            sys_rst <= 1'b1;
            timer   <= TW'(RST_CYCLES - 1);
            cause   <= btn_evt ? 4'b0010 : (wd_trig ? 4'b0100 : 4'b1000);
            count   <= (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
          end
        end
        HOLD: begin
          if (timer == '0) begin
            state   <= GUARD;
            sys_rst <= 1'b0;
            timer   <= TW'(GUARD_CYCLES - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GUARD: begin
          if (timer == '0)
            state <= IDLE;
          else
            timer <= timer - 1'b1;
        end
        default: begin
          state   <= IDLE;
          sys_rst <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign ack      = stb;
  assign data_out = (stb && !we) ? {8'b0, busy, 7'b0, count, 4'b0, cause} : 32'd0;

endmodule

// File: tb/tb_reset_ctrl.sv
// tb/tb_reset_ctrl.sv - directed self-checking bench for reset_ctrl
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_reset_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [15:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        btn_in;
  logic        wd_trig;
  logic        sys_rst;

  int total = 0;
  int bad   = 0;

  reset_ctrl #(.RST_CYCLES(4), .GUARD_CYCLES(3), .DB_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .data_in(data_in),
    .data_out(data_out), .ack(ack), .btn_in(btn_in), .wd_trig(wd_trig),
    .sys_rst(sys_rst)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(output logic [31:0] d);
    stb = 1'b1;
    we  = 1'b0;
    #1;
    d   = data_out;
    stb = 1'b0;
    #1;
  endtask

  task automatic sw_write(input logic [7:0] c);
    stb     = 1'b1;
    we      = 1'b1;
    data_in = {8'h00, c};
    step();
    stb     = 1'b0;
    we      = 1'b0;
    data_in = 16'h0000;
  endtask

  task automatic run_pulse(output int len);
    len = 0;
    while (sys_rst === 1'b1 && len < 50) begin
      len++;
      step();
    end
  endtask

  logic [31:0] rd;
  int          len;
  int          lat;
  logic        seen;

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; data_in = 16'h0; btn_in = 1'b0; wd_trig = 1'b0;

    // 1. power-on pulse
    step();
    rst = 1'b0;
    check("reset_sys_rst", {31'b0, sys_rst}, 32'd1);
    check("reset_data_out_idle", data_out, 32'd0);
    check("reset_ack_low", {31'b0, ack}, 32'd0);
    run_pulse(len);
    check("por_pulse_len", len, 4);
    read_reg(rd);
    check("por_guard_busy", rd, 32'h0080_0001);
    repeat (3) step();
    read_reg(rd);
    check("por_idle_regs", rd, 32'h0000_0001);
    stb = 1'b1; we = 1'b0; #1;
    check("ack_follows_stb", {31'b0, ack}, 32'd1);
    stb = 1'b0; #1;

    // 2. software restart and count saturation
    sw_write(8'h01);
    check("sw_sys_rst_rise", {31'b0, sys_rst}, 32'd1);
    run_pulse(len);
    check("sw_pulse_len", len, 4);
    repeat (3) step();
    read_reg(rd);
    check("sw_regs", rd, 32'h0000_0108);
    for (int i = 0; i < 299; i++) begin
      sw_write(8'h01);
      repeat (7) step();
    end
    read_reg(rd);
    check("count_saturate", rd, 32'h0000_FF08);

    // 3. watchdog during guard is dropped, in idle accepted
    sw_write(8'h02);
    read_reg(rd);
    check("clear_only", rd, 32'h0000_0008);
    sw_write(8'h01);
    run_pulse(len);
    check("sw2_pulse_len", len, 4);
    step();
    wd_trig = 1'b1;
    step();
    wd_trig = 1'b0;
    check("wd_guard_no_rst", {31'b0, sys_rst}, 32'd0);
    step();
    read_reg(rd);
    check("wd_guard_ignored", rd, 32'h0000_0108);
    wd_trig = 1'b1;
    step();
    wd_trig = 1'b0;
    check("wd_idle_rst", {31'b0, sys_rst}, 32'd1);
    run_pulse(len);
    check("wd_pulse_len", len, 4);
    repeat (3) step();
    read_reg(rd);
    check("wd_regs", rd, 32'h0000_0204);

    // 4. button debounce
    btn_in = 1'b1;
    repeat (4) step();
    btn_in = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (sys_rst === 1'b1) seen = 1'b1;
    end
    check("glitch_no_rst", {31'b0, seen}, 32'd0);
    btn_in = 1'b1;
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (sys_rst === 1'b1) break;
    end
    check("btn_latency", lat, 7);
    run_pulse(len);
    check("btn_pulse_len", len, 4);
    seen = 1'b0;
    repeat (15) begin
      step();
      if (sys_rst === 1'b1) seen = 1'b1;
    end
    check("btn_held_once", {31'b0, seen}, 32'd0);
    read_reg(rd);
    check("btn_regs", rd, 32'h0000_0302);
    btn_in = 1'b0;
    repeat (3) step();

    // 5. simultaneous requests, then clear+restart
    btn_in = 1'b1;
    repeat (6) step();
    wd_trig = 1'b1;
    sw_write(8'h01);
    wd_trig = 1'b0;
    check("simul_rst", {31'b0, sys_rst}, 32'd1);
    run_pulse(len);
    check("simul_pulse_len", len, 4);
    repeat (3) step();
    btn_in = 1'b0;
    read_reg(rd);
    check("simul_regs", rd, 32'h0000_0402);
    for (int i = 0; i < 5; i++) begin
      sw_write(8'h01);
      repeat (7) step();
    end
    read_reg(rd);
    check("count_nine", rd, 32'h0000_0908);
    sw_write(8'h03);
    check("clr_inc_rst", {31'b0, sys_rst}, 32'd1);
    run_pulse(len);
    check("clr_inc_pulse_len", len, 4);
    repeat (3) step();
    read_reg(rd);
    check("clr_inc_regs", rd, 32'h0000_0108);

    // 6. rst mid-HOLD restarts the hold
    sw_write(8'h01);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_pulse(len);
    check("midhold_pulse_len", len, 4);
    read_reg(rd);
    check("midhold_guard_regs", rd, 32'h0080_0001);
    repeat (3) step();
    read_reg(rd);
    check("midhold_idle_regs", rd, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
